c17_bist_ctrl: RTL

Built-in self-test controller for the c17 combinational block. It generates pseudo-random input patterns with a 5-bit LFSR and applies them to c17's five inputs. It compacts the two c17 outputs into an 8-bit MISR signature and compares that signature against a golden value. It sits between a test-access controller (start/done handshake) and the c17 instance, and owns the c17 inputs whenever it is not idle.

---
 rtl/c17_bist_pkg.sv | 46 ++++
 rtl/bist_misr.sv | 44 ++++
 rtl/c17_bist_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/c17_bist_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : c17_bist_pkg
//  Description : Shared types, constants and helpers for the c17 BIST
//                controller (state encoding, LFSR/MISR parameters, pin map).
//  Revision    : 1.0 - initial release
// ============================================================================
package c17_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INIT    = 3'd1,
    ST_APPLY   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_COMPARE = 3'd4,
    ST_DONE    = 3'd5
  } bist_state_t;

  localparam int          LFSR_W      = 5;
  localparam int          MISR_W      = 8;
  localparam logic [7:0]  MISR_POLY   = 8'h1D;  // x^8+x^4+x^3+x^2+1
  localparam int          LFSR_TAP_HI = 4;      // x^5+x^3+1
  localparam int          LFSR_TAP_LO = 2;

  // Pattern bit driving each c17 input pin
  localparam int PAT_X1 = 0;
  localparam int PAT_X2 = 1;
  localparam int PAT_X3 = 2;
  localparam int PAT_X6 = 3;
  localparam int PAT_X7 = 4;

  // Fibonacci LFSR step: shift left, feedback into bit 0
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    return {cur[LFSR_W-2:0], cur[LFSR_TAP_HI] ^ cur[LFSR_TAP_LO]};
  endfunction

  // MISR step: multiply by x modulo the polynomial, then fold in the response
  function automatic logic [MISR_W-1:0] misr_next(input logic [MISR_W-1:0] cur,
                                                  input logic [1:0]        din);
    return {cur[MISR_W-2:0], 1'b0}
         ^ (cur[MISR_W-1] ? MISR_POLY : '0)
         ^ {{(MISR_W-2){1'b0}}, din};
  endfunction

endpackage
`default_nettype wire

// File: rtl/bist_misr.sv
`default_nettype none
// ============================================================================
//  Module      : bist_misr
//  Description : 8-bit multiple-input signature register with synchronous
//                clear and enable, compacting a 2-bit response per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module bist_misr
  import c17_bist_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [1:0]        din,
  output logic [MISR_W-1:0] sig
);

  logic [MISR_W-1:0] sig_d;
  logic [MISR_W-1:0] sig_q;

  // Clear has priority over compaction
  always_comb begin
    sig_d = sig_q;
    if (clr) begin
      sig_d = '0;
    end else if (en) begin
      sig_d = misr_next(sig_q, din);
    end
  end

  // Signature register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule
`default_nettype wire

// File: rtl/c17_bist_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : c17_bist_ctrl
//  Description : BIST controller for c17: LFSR pattern generation, MISR
//                response compaction and golden-signature comparison behind
//                a start/done handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module c17_bist_ctrl
  import c17_bist_pkg::*;
#(
  parameter int          NPAT   = 31,
  parameter logic [4:0]  SEED   = 5'b00001,
  parameter logic [7:0]  GOLDEN = 8'h00
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              start,
  input  logic              abort,
  output logic [LFSR_W-1:0] pat_out,
  input  logic [1:0]        resp_in,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [MISR_W-1:0] signature,
  output logic [7:0]        pat_idx
);

  localparam logic [7:0] LAST_IDX = 8'(NPAT - 1);

  bist_state_t       state_q,   state_d;
  logic [LFSR_W-1:0] lfsr_q,    lfsr_d;
  logic [7:0]        pat_idx_q, pat_idx_d;
  logic              pass_q,    pass_d;
  logic              misr_clr;
  logic              misr_en;

  // Next-state, datapath updates and MISR controls; abort overrides all
  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    pat_idx_d = pat_idx_q;
    pass_d    = pass_q;
    misr_clr  = 1'b0;
    misr_en   = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
      pass_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) state_d = ST_INIT;
        end
        ST_INIT: begin
          lfsr_d    = SEED;
          misr_clr  = 1'b1;
          pat_idx_d = '0;
          pass_d    = 1'b0;
          state_d   = ST_APPLY;
        end
        ST_APPLY: begin
          // Pattern held for a full cycle so c17 settles before capture
          state_d = ST_CAPTURE;
        end
        ST_CAPTURE: begin
          misr_en = 1'b1;
          if (pat_idx_q == LAST_IDX) begin
            state_d = ST_COMPARE;
          end else begin
            pat_idx_d = pat_idx_q + 8'd1;
            lfsr_d    = lfsr_next(lfsr_q);
            state_d   = ST_APPLY;
          end
        end
        ST_COMPARE: begin
          pass_d  = (signature == GOLDEN);
          state_d = ST_DONE;
        end
        ST_DONE: begin
          if (start) state_d = ST_INIT;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Controller state registers
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      lfsr_q    <= SEED;
      pat_idx_q <= '0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      pat_idx_q <= pat_idx_d;
      pass_q    <= pass_d;
    end
  end

  bist_misr u_misr (
    .clk (CK),
    .rst (RST),
    .clr (misr_clr),
    .en  (misr_en),
    .din (resp_in),
    .sig (signature)
  );

  // Drive c17 only while a pattern is being applied or captured
  always_comb begin
    pat_out = '0;
    if (state_q == ST_APPLY || state_q == ST_CAPTURE) begin
      pat_out[PAT_X1] = lfsr_q[0];
      pat_out[PAT_X2] = lfsr_q[1];
      pat_out[PAT_X3] = lfsr_q[2];
      pat_out[PAT_X6] = lfsr_q[3];
      pat_out[PAT_X7] = lfsr_q[4];
    end
  end

  assign busy    = (state_q == ST_INIT) || (state_q == ST_APPLY) ||
                   (state_q == ST_CAPTURE) || (state_q == ST_COMPARE);
  assign done    = (state_q == ST_DONE);
  assign pass    = pass_q;
  assign pat_idx = pat_idx_q;

endmodule
`default_nettype wire
